// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type encodings and inter-stage bus layouts for MEM.
// Build option: MS_BYPASS_EN enables the MEM->ID forwarding outputs.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;

    typedef struct packed {
        logic [2:0]  ld_type;
        logic        mem_req;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
        return {{24{s & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
        return {{16{s & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: picks byte/half at the address offset
// and sign/zero extends it; unknown load types pass the word through.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_ld_type,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_data,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // select the addressed byte and halfword
    always_comb begin
        w_byte = i_data[7:0];
        unique case (i_offset)
            2'd0: w_byte = i_data[7:0];
            2'd1: w_byte = i_data[15:8];
            2'd2: w_byte = i_data[23:16];
            2'd3: w_byte = i_data[31:24];
        endcase
        w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
    end

    // extend according to the load type
    always_comb begin
        o_result = i_data;
        case (i_ld_type)
            LD_B:    o_result = ext8(w_byte, 1'b1);
            LD_BU:   o_result = ext8(w_byte, 1'b0);
            LD_H:    o_result = ext16(w_half, 1'b1);
            LD_HU:   o_result = ext16(w_half, 1'b0);
            default: o_result = i_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for load data,
// buffers an early response while WB stalls. Option: MS_BYPASS_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       ws_allowin,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 ms_to_ds_dest,
    output logic [31:0]                ms_to_ds_result,
    output logic                       ms_to_ds_load_pending
);

    es_to_ms_t   r_bus;
    logic        r_valid;
    logic        r_rdata_vld;
    logic [31:0] r_rdata;

    logic        w_ready_go;
    logic        w_leave;
    logic        w_latch;
    logic [31:0] w_load_data;
    logic [31:0] w_load_ext;
    logic [31:0] w_final;
    ms_to_ws_t   w_ws_bus;

    // handshake: a load is ready once data arrives now or was buffered
    always_comb begin
        w_ready_go     = !r_bus.mem_req || data_sram_data_ok || r_rdata_vld;
        ms_allowin     = !r_valid || (w_ready_go && ws_allowin);
        ms_to_ws_valid = r_valid && w_ready_go;
        w_leave        = ms_to_ws_valid && ws_allowin;
        w_latch        = r_valid && r_bus.mem_req && !r_rdata_vld
                         && data_sram_data_ok && !w_leave;
    end

    // valid bit and instruction bus register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else if (ms_allowin) begin
            r_valid <= es_to_ms_valid;
            if (es_to_ms_valid) begin
                r_bus <= es_to_ms_t'(es_to_ms_bus);
            end
        end
    end

    // hold a load response that arrives while WB is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata_vld <= 1'b0;
            r_rdata     <= '0;
        end else if (w_leave) begin
            r_rdata_vld <= 1'b0;
        end else if (w_latch) begin
            r_rdata_vld <= 1'b1;
            r_rdata     <= data_sram_rdata;
        end
    end

    // select load word source
    always_comb begin
        w_load_data = r_rdata_vld ? r_rdata : data_sram_rdata;
    end

    mem_load_align u_align (
        .i_ld_type (r_bus.ld_type),
        .i_offset  (r_bus.alu_result[1:0]),
        .i_data    (w_load_data),
        .o_result  (w_load_ext)
    );

    // result mux and WB bus packing
    always_comb begin
        w_final               = r_bus.mem_req ? w_load_ext : r_bus.alu_result;
        w_ws_bus.gr_we        = r_bus.gr_we;
        w_ws_bus.dest         = r_bus.dest;
        w_ws_bus.final_result = w_final;
        w_ws_bus.pc           = r_bus.pc;
        ms_to_ws_bus          = w_ws_bus;
        ms_to_ds_load_pending = r_valid && r_bus.mem_req && !w_ready_go;
    end

`ifdef MS_BYPASS_EN
    // forward destination and result to ID
    always_comb begin
        ms_to_ds_dest   = (r_valid && r_bus.gr_we) ? r_bus.dest : 5'd0;
        ms_to_ds_result = w_final;
    end
`else
    // no forwarding path; ID relies on interlock only
    always_comb begin
        ms_to_ds_dest   = 5'd0;
        ms_to_ds_result = 32'd0;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected WB bundles.
// Bypass expectations follow MS_BYPASS_EN.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_valid;
    logic [73:0] es_bus;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ws_allowin;
    logic        dok;
    logic [31:0] rdata;
    logic [4:0]  ds_dest;
    logic [31:0] ds_result;
    logic        ld_pend;

    int n_tests = 0;
    int n_fail  = 0;
    logic [69:0] sb[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .es_to_ms_valid        (es_valid),
        .es_to_ms_bus          (es_bus),
        .ms_allowin            (ms_allowin),
        .ms_to_ws_valid        (ms_to_ws_valid),
        .ms_to_ws_bus          (ms_to_ws_bus),
        .ws_allowin            (ws_allowin),
        .data_sram_data_ok     (dok),
        .data_sram_rdata       (rdata),
        .ms_to_ds_dest         (ds_dest),
        .ms_to_ds_result       (ds_result),
        .ms_to_ds_load_pending (ld_pend)
    );

    function automatic logic [73:0] mk_es(input logic [2:0] t, input logic m,
        input logic g, input logic [4:0] d, input logic [31:0] a,
        input logic [31:0] pc);
        return {t, m, g, d, a, pc};
    endfunction

    function automatic logic [69:0] mk_ws(input logic g, input logic [4:0] d,
        input logic [31:0] r, input logic [31:0] pc);
        return {g, d, r, pc};
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] t,
        input logic [1:0] off, input logic [31:0] d);
        logic [31:0] sb8;
        logic [31:0] sh16;
        sb8  = d >> (8 * int'(off));
        sh16 = d >> (16 * int'(off[1]));
        case (t)
            3'd1:    return {{24{sb8[7]}}, sb8[7:0]};
            3'd4:    return {24'd0, sb8[7:0]};
            3'd2:    return {{16{sh16[15]}}, sh16[15:0]};
            3'd5:    return {16'd0, sh16[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] byp_res(input logic [31:0] v);
`ifdef MS_BYPASS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs,
        input logic [69:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic [69:0] e;
        if (ms_to_ws_valid && ws_allowin) begin
            n_tests++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL wb_unexpected observed=%h expected=none",
                       ms_to_ws_bus);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wb_bus", ms_to_ws_bus, e);
            end
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        mon();
    endtask

    task automatic pedge();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  lt_tab[8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd1, 3'd4};
    logic [1:0]  of_tab[8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd3};

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        reset      = 1'b0;
        es_valid   = 1'b0;
        es_bus     = '0;
        ws_allowin = 1'b1;
        dok        = 1'b0;
        rdata      = '0;
        repeat (2) @(posedge clk);
        #1;

        nedge();
        chk("rst_allowin", 70'(ms_allowin), 70'(1));
        chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("rst_dest", 70'(ds_dest), 70'(0));
        chk("rst_pend", 70'(ld_pend), 70'(0));
        chk("rst_bus", ms_to_ws_bus, 70'(0));
        chk("rst_res", 70'(ds_result), 70'(0));
        pedge();
        reset = 1'b1;

        // non-load, one cycle of residency
        es_valid = 1'b1;
        es_bus = mk_es(3'd0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1c000000);
        sb.push_back(mk_ws(1'b1, 5'd5, 32'h12345678, 32'h1c000000));
        nedge();
        pedge();
        es_valid = 1'b0;
        nedge();
        chk("alu_valid", 70'(ms_to_ws_valid), 70'(1));
`ifdef MS_BYPASS_EN
        chk("alu_dsdest", 70'(ds_dest), 70'(5));
`else
        chk("alu_dsdest", 70'(ds_dest), 70'(0));
`endif
        chk("alu_dsres", 70'(ds_result), 70'(byp_res(32'h12345678)));
        pedge();

        // ld.b then ld.bu entering as ld.b leaves
        es_valid = 1'b1;
        es_bus = mk_es(3'd1, 1'b1, 1'b1, 5'd7, 32'h1c000103, 32'h1c000010);
        sb.push_back(mk_ws(1'b1, 5'd7, 32'hFFFFFF80, 32'h1c000010));
        nedge();
        pedge();
        es_bus = mk_es(3'd4, 1'b1, 1'b1, 5'd8, 32'h1c000103, 32'h1c000014);
        sb.push_back(mk_ws(1'b1, 5'd8, 32'h00000080, 32'h1c000014));
        dok   = 1'b1;
        rdata = 32'h80FF00AA;
        nedge();
        chk("ldb_allowin", 70'(ms_allowin), 70'(1));
        pedge();
        es_valid = 1'b0;
        nedge();
        chk("ldbu_valid", 70'(ms_to_ws_valid), 70'(1));
        pedge();
        dok = 1'b0;

        // ld.h with data three cycles late
        es_valid = 1'b1;
        es_bus = mk_es(3'd2, 1'b1, 1'b1, 5'd9, 32'h1c001002, 32'h1c000018);
        sb.push_back(mk_ws(1'b1, 5'd9, 32'hFFFF8001, 32'h1c000018));
        nedge();
        pedge();
        es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nedge();
            chk("ldh_pend", 70'(ld_pend), 70'(1));
            chk("ldh_allowin", 70'(ms_allowin), 70'(0));
            chk("ldh_valid", 70'(ms_to_ws_valid), 70'(0));
            pedge();
        end
        dok   = 1'b1;
        rdata = 32'h80017FFF;
        nedge();
        chk("ldh_pend_done", 70'(ld_pend), 70'(0));
        pedge();
        dok = 1'b0;

        // ld.w response buffered across a 4-cycle WB stall
        ws_allowin = 1'b0;
        es_valid   = 1'b1;
        es_bus = mk_es(3'd0, 1'b1, 1'b1, 5'd10, 32'h1c002000, 32'h1c00001c);
        sb.push_back(mk_ws(1'b1, 5'd10, 32'hDEADBEEF, 32'h1c00001c));
        nedge();
        pedge();
        es_valid = 1'b0;
        dok      = 1'b1;
        rdata    = 32'hDEADBEEF;
        nedge();
        chk("ldw_valid", 70'(ms_to_ws_valid), 70'(1));
        pedge();
        dok   = 1'b0;
        rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            nedge();
            chk("buf_valid", 70'(ms_to_ws_valid), 70'(1));
            chk("buf_allowin", 70'(ms_allowin), 70'(0));
            chk("buf_data", 70'(ms_to_ws_bus[63:32]), 70'(32'hDEADBEEF));
            pedge();
        end
        ws_allowin = 1'b1;
        es_valid   = 1'b1;
        es_bus = mk_es(3'd5, 1'b1, 1'b1, 5'd11, 32'h1c003002, 32'h1c000020);
        sb.push_back(mk_ws(1'b1, 5'd11, 32'h00001234, 32'h1c000020));
        nedge();
        chk("swap_allowin", 70'(ms_allowin), 70'(1));
        pedge();
        es_valid = 1'b0;
        nedge();
        chk("buf_cleared", 70'(ld_pend), 70'(1));
        pedge();
        dok   = 1'b1;
        rdata = 32'h1234ABCD;
        nedge();
        pedge();
        dok = 1'b0;

        // all load types and offsets
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            a = 32'h1c004000 | 32'(of_tab[i]);
            es_valid = 1'b1;
            es_bus = mk_es(lt_tab[i], 1'b1, 1'b1, 5'(i + 12), a, 32'(i * 4));
            sb.push_back(mk_ws(1'b1, 5'(i + 12),
                               model_ld(lt_tab[i], of_tab[i], d), 32'(i * 4)));
            nedge();
            pedge();
            es_valid = 1'b0;
            dok      = 1'b1;
            rdata    = d;
            nedge();
            pedge();
            dok = 1'b0;
        end

        // back-to-back non-loads, then a WB stall
        for (int i = 0; i < 4; i++) begin
            es_valid = 1'b1;
            es_bus = mk_es(3'd0, 1'b0, 1'b1, 5'(i + 1), 32'(i * 3 + 7),
                           32'(32'h100 + i * 4));
            sb.push_back(mk_ws(1'b1, 5'(i + 1), 32'(i * 3 + 7),
                               32'(32'h100 + i * 4)));
            nedge();
            chk("b2b_allowin", 70'(ms_allowin), 70'(1));
            chk("b2b_valid", 70'(ms_to_ws_valid), 70'(i > 0));
            pedge();
        end
        ws_allowin = 1'b0;
        es_bus = mk_es(3'd0, 1'b0, 1'b0, 5'd20, 32'hCAFE0000, 32'h200);
        sb.push_back(mk_ws(1'b0, 5'd20, 32'hCAFE0000, 32'h200));
        for (int i = 0; i < 3; i++) begin
            nedge();
            chk("stall_allowin", 70'(ms_allowin), 70'(0));
            chk("stall_bus", ms_to_ws_bus, mk_ws(1'b1, 5'd4, 32'd16, 32'h10c));
            pedge();
        end
        ws_allowin = 1'b1;
        nedge();
        pedge();
        es_valid = 1'b0;
        nedge();
        chk("nowe_dest", 70'(ds_dest), 70'(0));
        pedge();

        // reset during WAIT discards the load
        es_valid = 1'b1;
        es_bus = mk_es(3'd0, 1'b1, 1'b1, 5'd12, 32'h1c005000, 32'h300);
        nedge();
        pedge();
        es_valid = 1'b0;
        nedge();
        chk("wait_pend", 70'(ld_pend), 70'(1));
`ifdef MS_BYPASS_EN
        chk("wait_dest", 70'(ds_dest), 70'(12));
`else
        chk("wait_dest", 70'(ds_dest), 70'(0));
`endif
        reset = 1'b0;
        #1;
        chk("arst_valid", 70'(ms_to_ws_valid), 70'(0));
        chk("arst_allowin", 70'(ms_allowin), 70'(1));
        chk("arst_pend", 70'(ld_pend), 70'(0));
        chk("arst_dest", 70'(ds_dest), 70'(0));
        pedge();
        reset = 1'b1;
        dok   = 1'b1;
        rdata = 32'h55AA55AA;
        nedge();
        chk("late_ok_valid", 70'(ms_to_ws_valid), 70'(0));
        pedge();
        dok = 1'b0;
        es_valid = 1'b1;
        es_bus = mk_es(3'd0, 1'b1, 1'b1, 5'd13, 32'h1c006000, 32'h304);
        sb.push_back(mk_ws(1'b1, 5'd13, 32'h0BADF00D, 32'h304));
        nedge();
        pedge();
        es_valid = 1'b0;
        nedge();
        chk("late_ok_ignored", 70'(ld_pend), 70'(1));
        pedge();
        dok   = 1'b1;
        rdata = 32'h0BADF00D;
        nedge();
        pedge();
        dok = 1'b0;
        nedge();
        chk("sb_empty", 70'(sb.size()), 70'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
